// File: rtl/fre_div_pkg.sv
// Shared types and defaults for the programmable lw/hw clock divider.
// Build option: FRE_DIV_HALF_CYCLE_EN adds the half-cycle duty trim.
package fre_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_e;

    localparam int LW_DEF_C = 2;
    localparam int HW_DEF_C = 3;

    // Both phase lengths must be nonzero; callers zero-extend their CW-bit fields.
    function automatic logic cfg_ok(input logic [31:0] lw, input logic [31:0] hw);
        return (lw != 32'd0) && (hw != 32'd0);
    endfunction

endpackage

// File: rtl/fre_div_prog_if.sv
// Config port of the divider: cfg_valid/cfg_ready request plus error pulse.
// Build option: FRE_DIV_HALF_CYCLE_EN adds cfg_half.
interface fre_div_prog_if #(
    parameter int CW = 8
);
    // A request transfers on a posedge where cfg_valid & cfg_ready are both high;
    // the master holds cfg_lw/cfg_hw stable while cfg_valid is high and not yet taken.
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_lw;
    logic [CW-1:0] cfg_hw;
    logic          cfg_err;
`ifdef FRE_DIV_HALF_CYCLE_EN
    logic          cfg_half;

    modport master (output cfg_valid, cfg_lw, cfg_hw, cfg_half, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_lw, cfg_hw, cfg_half, output cfg_ready, cfg_err);
`else
    modport master (output cfg_valid, cfg_lw, cfg_hw, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_lw, cfg_hw, output cfg_ready, cfg_err);
`endif
endinterface

// File: rtl/fre_div_cfg_shadow.sv
// Shadow/active count registers with a single pending slot for new configs.
// Build option: FRE_DIV_HALF_CYCLE_EN also carries the half-cycle flag.
module fre_div_cfg_shadow
    import fre_div_pkg::*;
#(
    parameter int CW     = 8,
    parameter int LW_DEF = LW_DEF_C,
    parameter int HW_DEF = HW_DEF_C
) (
    input  logic          clk,
    input  logic          rst_n,
    fre_div_prog_if.slave cfg,
    input  logic          i_boundary,
`ifdef FRE_DIV_HALF_CYCLE_EN
    output logic          o_act_half,
`endif
    output logic [CW-1:0] o_act_lw,
    output logic [CW-1:0] o_act_hw
);

    logic          r_pending;
    logic          r_err;
    logic [CW-1:0] r_sh_lw;
    logic [CW-1:0] r_sh_hw;
    logic [CW-1:0] r_act_lw;
    logic [CW-1:0] r_act_hw;
    logic          w_fire;
    logic          w_ok;

    assign w_fire = cfg.cfg_valid & ~r_pending;

`ifdef FRE_DIV_HALF_CYCLE_EN
    logic r_sh_half;
    logic r_act_half;

    // A half-cycle trim needs at least one full low cycle to borrow from.
    assign w_ok = cfg_ok(32'(cfg.cfg_lw), 32'(cfg.cfg_hw))
                  & ~(cfg.cfg_half & (cfg.cfg_lw == CW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_half  <= 1'b0;
            r_act_half <= 1'b0;
        end else if (i_boundary && r_pending) begin
            r_act_half <= r_sh_half;
        end else if (w_fire && w_ok) begin
            r_sh_half  <= cfg.cfg_half;
        end
    end

    assign o_act_half = r_act_half;
`else
    assign w_ok = cfg_ok(32'(cfg.cfg_lw), 32'(cfg.cfg_hw));
`endif

    // Apply and accept never coincide: apply needs pending set, accept needs it clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_err     <= 1'b0;
            r_sh_lw   <= CW'(LW_DEF);
            r_sh_hw   <= CW'(HW_DEF);
            r_act_lw  <= CW'(LW_DEF);
            r_act_hw  <= CW'(HW_DEF);
        end else begin
            r_err <= w_fire & ~w_ok;
            if (i_boundary && r_pending) begin
                r_act_lw  <= r_sh_lw;
                r_act_hw  <= r_sh_hw;
                r_pending <= 1'b0;
            end else if (w_fire && w_ok) begin
                r_sh_lw   <= cfg.cfg_lw;
                r_sh_hw   <= cfg.cfg_hw;
                r_pending <= 1'b1;
            end
        end
    end

    assign cfg.cfg_ready = ~r_pending;
    assign cfg.cfg_err   = r_err;
    assign o_act_lw      = r_act_lw;
    assign o_act_hw      = r_act_hw;

endmodule

// File: rtl/fre_div_prog.sv
// Runtime-programmable divider: out_div low for LW cycles then high for HW cycles.
// Build option: FRE_DIV_HALF_CYCLE_EN stretches the high phase by half a clk period.
module fre_div_prog
    import fre_div_pkg::*;
#(
    parameter int CW     = 8,
    parameter int LW_DEF = LW_DEF_C,
    parameter int HW_DEF = HW_DEF_C
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    fre_div_prog_if.slave cfg,
    output logic          out_div,
    output logic          tick_rise,
    output logic          period_done,
    output logic          busy,
    output state_e        dbg_state
);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_out;
    logic          r_tick;
    logic          r_pdone;
    logic [CW-1:0] w_act_lw;
    logic [CW-1:0] w_act_hw;
    logic [CW-1:0] w_cnt_inc;
    logic          w_low_end;
    logic          w_high_end;
    logic          w_boundary;

    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_low_end  = (r_cnt >= w_act_lw);
    assign w_high_end = (r_cnt >= w_act_hw);
    // Counts may only change while idle or on the edge that closes a period.
    assign w_boundary = (r_state == IDLE) | ((r_state == HIGH) & w_high_end);

    fre_div_cfg_shadow #(
        .CW     (CW),
        .LW_DEF (LW_DEF),
        .HW_DEF (HW_DEF)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg),
        .i_boundary (w_boundary),
`ifdef FRE_DIV_HALF_CYCLE_EN
        .o_act_half (w_act_half),
`endif
        .o_act_lw   (w_act_lw),
        .o_act_hw   (w_act_hw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_tick  <= 1'b0;
            r_pdone <= 1'b0;
        end else if (!en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_tick  <= 1'b0;
            r_pdone <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_pdone <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state <= LOW;
                    r_cnt   <= CW'(1);
                    r_out   <= 1'b0;
                end
                LOW: begin
                    if (!w_low_end) begin
                        r_cnt <= w_cnt_inc;
                    end else begin
                        r_state <= HIGH;
                        r_cnt   <= CW'(1);
                        r_out   <= 1'b1;
                        r_tick  <= 1'b1;
                        r_pdone <= (w_act_hw == CW'(1));
                    end
                end
                HIGH: begin
                    if (!w_high_end) begin
                        r_cnt   <= w_cnt_inc;
                        r_pdone <= (w_cnt_inc == w_act_hw);
                    end else begin
                        r_state <= LOW;
                        r_cnt   <= CW'(1);
                        r_out   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRE_DIV_HALF_CYCLE_EN
    logic w_act_half;
    logic r_half_ext;

    // Falls half a period after r_out, so the OR delays only the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) r_half_ext <= 1'b0;
        else        r_half_ext <= r_out & w_act_half;
    end

    assign out_div = r_out | r_half_ext;
`else
    assign out_div = r_out;
`endif

    assign tick_rise   = r_tick;
    assign period_done = r_pdone;
    assign busy        = (r_state != IDLE);
    assign dbg_state   = r_state;

endmodule
